tl_ul_a_arbiter_2to1: RTL and testbench

Two-to-one TileLink-UL arbiter that shares a single 32-bit TL-UL manager port, such as the E21 system/peripheral port, between two client requesters. It arbitrates channel A round-robin, keeping a grant locked across multi-beat Put bursts. It tags each request's source with the originating requester and routes channel D responses back by that tag. It sits directly upstream of the TL monitor on the shared link, so every legal client stream must remain a legal TL-UL stream on the manager side.

---
 rtl/tl_ul_pkg.sv | 39 +++
 rtl/tl_inflight_ctr.sv | 53 +++++
 rtl/tl_ul_a_arbiter_2to1.sv | 243 ++++++++++++++++++++++++
 tb/tb_tl_ul_a_arbiter_2to1.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_ul_pkg.sv
// Shared TL-UL definitions for the 2:1 channel-A arbiter: field widths,
// opcode constants, FSM state type and the beat-count helpers.
package tl_ul_pkg;

  localparam int OPC_W     = 3;
  localparam int A_PARAM_W = 3;
  localparam int D_PARAM_W = 2;
  localparam int SIZE_W    = 2;
  localparam int ADDR_W    = 30;
  localparam int MASK_W    = 4;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 4;

  localparam logic [OPC_W-1:0] A_PUT_FULL_DATA    = 3'd0;
  localparam logic [OPC_W-1:0] A_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [OPC_W-1:0] A_GET              = 3'd4;
  localparam logic [OPC_W-1:0] D_ACCESS_ACK       = 3'd0;
  localparam logic [OPC_W-1:0] D_ACCESS_ACK_DATA  = 3'd1;

  // 8-byte transfers on a 32-bit link take two beats
  localparam logic [SIZE_W-1:0] SIZE_TWO_BEAT = 2'd3;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic logic a_is_two_beat(input logic [OPC_W-1:0] opcode,
                                         input logic [SIZE_W-1:0] size);
    return ((opcode == A_PUT_FULL_DATA) || (opcode == A_PUT_PARTIAL_DATA)) &&
           (size == SIZE_TWO_BEAT);
  endfunction

  function automatic logic d_is_two_beat(input logic [OPC_W-1:0] opcode,
                                         input logic [SIZE_W-1:0] size);
    return (opcode == D_ACCESS_ACK_DATA) && (size == SIZE_TWO_BEAT);
  endfunction

endpackage

// File: rtl/tl_inflight_ctr.sv
// Per-client outstanding-request counter: counts first A beats up and last
// D beats down, saturating at zero on a stray response.
module tl_inflight_ctr
  import tl_ul_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count; simultaneous inc and dec cancel
  always_comb begin
    count_d = count_q;
    if (inc && !dec) begin
      if (count_q != 4'hF) begin
        count_d = count_q + 4'd1;
      end else begin
        count_d = count_q;
      end
    end else if (dec && !inc) begin
      if (count_q != 4'd0) begin
        count_d = count_q - 4'd1;
      end else begin
        count_d = 4'd0;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q >= MAX_CNT);

endmodule

// File: rtl/tl_ul_a_arbiter_2to1.sv
// Two-client TL-UL arbiter: round-robin on channel A with burst locking and
// stall-stable grants, source tagging, and tag-based channel D routing.
module tl_ul_a_arbiter_2to1
  import tl_ul_pkg::*;
#(
  parameter int SRC_W        = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                 clock,
  input  logic                 reset,

  input  logic                 c0_a_valid,
  output logic                 c0_a_ready,
  input  logic [OPC_W-1:0]     c0_a_opcode,
  input  logic [A_PARAM_W-1:0] c0_a_param,
  input  logic [SIZE_W-1:0]    c0_a_size,
  input  logic [SRC_W-1:0]     c0_a_source,
  input  logic [ADDR_W-1:0]    c0_a_address,
  input  logic [MASK_W-1:0]    c0_a_mask,
  input  logic [DATA_W-1:0]    c0_a_data,
  output logic                 c0_d_valid,
  input  logic                 c0_d_ready,
  output logic [OPC_W-1:0]     c0_d_opcode,
  output logic [D_PARAM_W-1:0] c0_d_param,
  output logic [SIZE_W-1:0]    c0_d_size,
  output logic [SRC_W-1:0]     c0_d_source,
  output logic                 c0_d_denied,
  output logic [DATA_W-1:0]    c0_d_data,

  input  logic                 c1_a_valid,
  output logic                 c1_a_ready,
  input  logic [OPC_W-1:0]     c1_a_opcode,
  input  logic [A_PARAM_W-1:0] c1_a_param,
  input  logic [SIZE_W-1:0]    c1_a_size,
  input  logic [SRC_W-1:0]     c1_a_source,
  input  logic [ADDR_W-1:0]    c1_a_address,
  input  logic [MASK_W-1:0]    c1_a_mask,
  input  logic [DATA_W-1:0]    c1_a_data,
  output logic                 c1_d_valid,
  input  logic                 c1_d_ready,
  output logic [OPC_W-1:0]     c1_d_opcode,
  output logic [D_PARAM_W-1:0] c1_d_param,
  output logic [SIZE_W-1:0]    c1_d_size,
  output logic [SRC_W-1:0]     c1_d_source,
  output logic                 c1_d_denied,
  output logic [DATA_W-1:0]    c1_d_data,

  output logic                 m_a_valid,
  input  logic                 m_a_ready,
  output logic [OPC_W-1:0]     m_a_opcode,
  output logic [A_PARAM_W-1:0] m_a_param,
  output logic [SIZE_W-1:0]    m_a_size,
  output logic [SRC_W:0]       m_a_source,
  output logic [ADDR_W-1:0]    m_a_address,
  output logic [MASK_W-1:0]    m_a_mask,
  output logic [DATA_W-1:0]    m_a_data,
  input  logic                 m_d_valid,
  output logic                 m_d_ready,
  input  logic [OPC_W-1:0]     m_d_opcode,
  input  logic [D_PARAM_W-1:0] m_d_param,
  input  logic [SIZE_W-1:0]    m_d_size,
  input  logic [SRC_W:0]       m_d_source,
  input  logic                 m_d_denied,
  input  logic [DATA_W-1:0]    m_d_data
);

  arb_state_e state_q, state_d;
  logic       rr_last_q, rr_last_d;
  logic       pend_q, pend_d;
  logic       hold_idx_q, hold_idx_d;
  logic       a_beat_q, a_beat_d;
  logic       d_beat_q, d_beat_d;

  logic       elig0_s, elig1_s;
  logic       gnt_valid_s, gnt_idx_s, sel_valid_s;
  logic       a_fire_s, a_first_s, a_multi_s;
  logic       d_idx_s, d_fire_s, d_multi_s, d_last_s;
  logic [1:0] inc_s, dec_s, full_s;
  logic [CNT_W-1:0] cnt0_s, cnt1_s;

  tl_inflight_ctr #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_ctr0 (
    .clock (clock),
    .reset (reset),
    .inc   (inc_s[0]),
    .dec   (dec_s[0]),
    .full  (full_s[0]),
    .count (cnt0_s)
  );

  tl_inflight_ctr #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_ctr1 (
    .clock (clock),
    .reset (reset),
    .inc   (inc_s[1]),
    .dec   (dec_s[1]),
    .full  (full_s[1]),
    .count (cnt1_s)
  );

  assign elig0_s = c0_a_valid & ~full_s[0];
  assign elig1_s = c1_a_valid & ~full_s[1];

  // Grant selection: a locked burst or a stalled beat keeps its owner
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_idx_s   = 1'b0;
    if ((state_q == ARB_LOCKED) || pend_q) begin
      gnt_valid_s = 1'b1;
      gnt_idx_s   = hold_idx_q;
    end else if (elig0_s && elig1_s) begin
      gnt_valid_s = 1'b1;
      gnt_idx_s   = ~rr_last_q;
    end else if (elig0_s) begin
      gnt_valid_s = 1'b1;
      gnt_idx_s   = 1'b0;
    end else if (elig1_s) begin
      gnt_valid_s = 1'b1;
      gnt_idx_s   = 1'b1;
    end else begin
      gnt_valid_s = 1'b0;
      gnt_idx_s   = 1'b0;
    end
  end

  // Channel A field mux with the requester index prepended to the source
  always_comb begin
    if (gnt_idx_s) begin
      sel_valid_s = c1_a_valid;
      m_a_opcode  = c1_a_opcode;
      m_a_param   = c1_a_param;
      m_a_size    = c1_a_size;
      m_a_source  = {1'b1, c1_a_source};
      m_a_address = c1_a_address;
      m_a_mask    = c1_a_mask;
      m_a_data    = c1_a_data;
    end else begin
      sel_valid_s = c0_a_valid;
      m_a_opcode  = c0_a_opcode;
      m_a_param   = c0_a_param;
      m_a_size    = c0_a_size;
      m_a_source  = {1'b0, c0_a_source};
      m_a_address = c0_a_address;
      m_a_mask    = c0_a_mask;
      m_a_data    = c0_a_data;
    end
  end

  assign m_a_valid  = gnt_valid_s & sel_valid_s & ~reset;
  assign c0_a_ready = m_a_ready & gnt_valid_s & ~gnt_idx_s & ~reset;
  assign c1_a_ready = m_a_ready & gnt_valid_s &  gnt_idx_s & ~reset;
  assign a_fire_s   = m_a_valid & m_a_ready;
  assign a_first_s  = ~a_beat_q;
  assign a_multi_s  = a_is_two_beat(m_a_opcode, m_a_size);

  // Arbiter FSM next state, round-robin pointer and grant hold
  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    a_beat_d   = a_beat_q;
    pend_d     = m_a_valid & ~m_a_ready;
    hold_idx_d = gnt_valid_s ? gnt_idx_s : hold_idx_q;
    case (state_q)
      ARB_IDLE: begin
        if (a_fire_s && a_multi_s) begin
          state_d  = ARB_LOCKED;
          a_beat_d = 1'b1;
        end else if (a_fire_s) begin
          rr_last_d = gnt_idx_s;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_LOCKED: begin
        if (a_fire_s) begin
          state_d   = ARB_IDLE;
          a_beat_d  = 1'b0;
          rr_last_d = gnt_idx_s;
        end else begin
          state_d = ARB_LOCKED;
        end
      end
      default: begin
        state_d  = ARB_IDLE;
        a_beat_d = 1'b0;
      end
    endcase
  end

  assign inc_s[0] = a_fire_s & a_first_s & ~gnt_idx_s;
  assign inc_s[1] = a_fire_s & a_first_s &  gnt_idx_s;

  // Channel D routing by the tag bit; payload is broadcast, valid is not
  assign d_idx_s    = m_d_source[SRC_W];
  assign c0_d_valid = m_d_valid & ~d_idx_s & ~reset;
  assign c1_d_valid = m_d_valid &  d_idx_s & ~reset;
  assign m_d_ready  = d_idx_s ? c1_d_ready : c0_d_ready;
  assign d_fire_s   = m_d_valid & m_d_ready;
  assign d_multi_s  = d_is_two_beat(m_d_opcode, m_d_size);
  assign d_last_s   = ~d_multi_s | d_beat_q;
  assign dec_s[0]   = d_fire_s & d_last_s & ~d_idx_s;
  assign dec_s[1]   = d_fire_s & d_last_s &  d_idx_s;

  assign c0_d_opcode = m_d_opcode;
  assign c0_d_param  = m_d_param;
  assign c0_d_size   = m_d_size;
  assign c0_d_source = m_d_source[SRC_W-1:0];
  assign c0_d_denied = m_d_denied;
  assign c0_d_data   = m_d_data;
  assign c1_d_opcode = m_d_opcode;
  assign c1_d_param  = m_d_param;
  assign c1_d_size   = m_d_size;
  assign c1_d_source = m_d_source[SRC_W-1:0];
  assign c1_d_denied = m_d_denied;
  assign c1_d_data   = m_d_data;

  // D beat position within a two-beat response
  always_comb begin
    if (d_fire_s) begin
      d_beat_d = d_multi_s & ~d_beat_q;
    end else begin
      d_beat_d = d_beat_q;
    end
  end

  // State registers; rr_last resets to client 1 so client 0 wins first
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      rr_last_q  <= 1'b1;
      pend_q     <= 1'b0;
      hold_idx_q <= 1'b0;
      a_beat_q   <= 1'b0;
      d_beat_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      pend_q     <= pend_d;
      hold_idx_q <= hold_idx_d;
      a_beat_q   <= a_beat_d;
      d_beat_q   <= d_beat_d;
    end
  end

endmodule

// File: tb/tb_tl_ul_a_arbiter_2to1.sv
// Scoreboard bench for tl_ul_a_arbiter_2to1: queue-driven clients, expected
// A and D beats queued at stimulus time and checked by negedge monitors.
module tb_tl_ul_a_arbiter_2to1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        c0_a_valid, c0_a_ready, c1_a_valid, c1_a_ready;
  logic [2:0]  c0_a_opcode, c0_a_param, c1_a_opcode, c1_a_param;
  logic [1:0]  c0_a_size, c0_a_source, c1_a_size, c1_a_source;
  logic [29:0] c0_a_address, c1_a_address;
  logic [3:0]  c0_a_mask, c1_a_mask;
  logic [31:0] c0_a_data, c1_a_data;
  logic        c0_d_valid, c0_d_ready, c0_d_denied, c1_d_valid, c1_d_ready, c1_d_denied;
  logic [2:0]  c0_d_opcode, c1_d_opcode;
  logic [1:0]  c0_d_param, c0_d_size, c0_d_source, c1_d_param, c1_d_size, c1_d_source;
  logic [31:0] c0_d_data, c1_d_data;
  logic        m_a_valid, m_a_ready, m_d_valid, m_d_ready, m_d_denied;
  logic [2:0]  m_a_opcode, m_a_param, m_a_source, m_d_opcode, m_d_source;
  logic [1:0]  m_a_size, m_d_param, m_d_size;
  logic [29:0] m_a_address;
  logic [3:0]  m_a_mask;
  logic [31:0] m_a_data, m_d_data;

  tl_ul_a_arbiter_2to1 #(.SRC_W(2), .MAX_INFLIGHT(4)) dut (
    .clock(clock), .reset(reset),
    .c0_a_valid(c0_a_valid), .c0_a_ready(c0_a_ready), .c0_a_opcode(c0_a_opcode),
    .c0_a_param(c0_a_param), .c0_a_size(c0_a_size), .c0_a_source(c0_a_source),
    .c0_a_address(c0_a_address), .c0_a_mask(c0_a_mask), .c0_a_data(c0_a_data),
    .c0_d_valid(c0_d_valid), .c0_d_ready(c0_d_ready), .c0_d_opcode(c0_d_opcode),
    .c0_d_param(c0_d_param), .c0_d_size(c0_d_size), .c0_d_source(c0_d_source),
    .c0_d_denied(c0_d_denied), .c0_d_data(c0_d_data),
    .c1_a_valid(c1_a_valid), .c1_a_ready(c1_a_ready), .c1_a_opcode(c1_a_opcode),
    .c1_a_param(c1_a_param), .c1_a_size(c1_a_size), .c1_a_source(c1_a_source),
    .c1_a_address(c1_a_address), .c1_a_mask(c1_a_mask), .c1_a_data(c1_a_data),
    .c1_d_valid(c1_d_valid), .c1_d_ready(c1_d_ready), .c1_d_opcode(c1_d_opcode),
    .c1_d_param(c1_d_param), .c1_d_size(c1_d_size), .c1_d_source(c1_d_source),
    .c1_d_denied(c1_d_denied), .c1_d_data(c1_d_data),
    .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_opcode(m_a_opcode),
    .m_a_param(m_a_param), .m_a_size(m_a_size), .m_a_source(m_a_source),
    .m_a_address(m_a_address), .m_a_mask(m_a_mask), .m_a_data(m_a_data),
    .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_opcode(m_d_opcode),
    .m_d_param(m_d_param), .m_d_size(m_d_size), .m_d_source(m_d_source),
    .m_d_denied(m_d_denied), .m_d_data(m_d_data)
  );

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic [1:0]  source;
    logic [29:0] address;
    logic [31:0] data;
  } beat_t;

  beat_t       c0q[$];
  beat_t       c1q[$];
  logic [95:0] exp_a[$];
  logic [95:0] exp_d[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic beat_t mk(input logic [2:0] o, input logic [1:0] z, input logic [1:0] s,
                               input logic [29:0] a, input logic [31:0] d);
    beat_t b;
    b.opcode = o; b.size = z; b.source = s; b.address = a; b.data = d;
    return b;
  endfunction

  function automatic logic [95:0] akey(input logic [2:0] s, input logic [2:0] o,
                                       input logic [1:0] z, input logic [29:0] a,
                                       input logic [31:0] d);
    return {26'd0, s, o, z, a, d};
  endfunction

  function automatic logic [95:0] dkey(input logic c, input logic [1:0] s, input logic [2:0] o,
                                       input logic [1:0] z, input logic [31:0] d);
    return {56'd0, c, s, o, z, d};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic cq_push(input logic cl, input beat_t b);
    if (cl) c1q.push_back(b);
    else c0q.push_back(b);
  endtask

  task automatic exp_push(input logic cl, input beat_t b);
    exp_a.push_back(akey({cl, b.source}, b.opcode, b.size, b.address, b.data));
  endtask

  task automatic wait_a_drain(input string name);
    int n = 0;
    while (exp_a.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk(name, 96'(exp_a.size()), 96'(0));
  endtask

  task automatic d_send(input logic [2:0] s, input logic [2:0] o, input logic [1:0] z,
                        input logic [31:0] d);
    int n = 0;
    exp_d.push_back(dkey(s[2], s[1:0], o, z, d));
    m_d_valid = 1'b1; m_d_source = s; m_d_opcode = o; m_d_size = z; m_d_data = d;
    while (!m_d_ready && n < 20) begin
      step();
      n++;
    end
    if (!m_d_ready) begin
      n_checks++;
      $display("FAIL d_ready_timeout: actual m_d_ready 0 required 1");
    end
    step();
    m_d_valid = 1'b0;
  endtask

  // Client drivers: present queue head, pop after a handshake seen at negedge
  initial begin : drv0
    logic f;
    c0_a_valid = 1'b0; c0_a_opcode = 3'd0; c0_a_param = 3'd0; c0_a_size = 2'd0;
    c0_a_source = 2'd0; c0_a_address = 30'd0; c0_a_mask = 4'hF; c0_a_data = 32'd0;
    forever begin
      @(negedge clock);
      f = c0_a_valid & c0_a_ready;
      @(posedge clock);
      #1;
      if (f && c0q.size() > 0) void'(c0q.pop_front());
      if (c0q.size() > 0) begin
        c0_a_valid = 1'b1; c0_a_opcode = c0q[0].opcode; c0_a_size = c0q[0].size;
        c0_a_source = c0q[0].source; c0_a_address = c0q[0].address; c0_a_data = c0q[0].data;
      end else begin
        c0_a_valid = 1'b0;
      end
    end
  end

  initial begin : drv1
    logic f;
    c1_a_valid = 1'b0; c1_a_opcode = 3'd0; c1_a_param = 3'd0; c1_a_size = 2'd0;
    c1_a_source = 2'd0; c1_a_address = 30'd0; c1_a_mask = 4'hF; c1_a_data = 32'd0;
    forever begin
      @(negedge clock);
      f = c1_a_valid & c1_a_ready;
      @(posedge clock);
      #1;
      if (f && c1q.size() > 0) void'(c1q.pop_front());
      if (c1q.size() > 0) begin
        c1_a_valid = 1'b1; c1_a_opcode = c1q[0].opcode; c1_a_size = c1q[0].size;
        c1_a_source = c1q[0].source; c1_a_address = c1q[0].address; c1_a_data = c1q[0].data;
      end else begin
        c1_a_valid = 1'b0;
      end
    end
  end

  // Manager-side A monitor
  initial begin : mon_a
    forever begin
      @(negedge clock);
      if (!reset && m_a_valid && m_a_ready) begin
        if (exp_a.size() == 0) begin
          n_checks++;
          $display("FAIL a_unexpected: actual beat source %0h addr %0h, required none",
                   m_a_source, m_a_address);
        end else begin
          chk("a_beat", akey(m_a_source, m_a_opcode, m_a_size, m_a_address, m_a_data),
              exp_a.pop_front());
        end
      end
    end
  end

  // Client-side D monitor
  initial begin : mon_d
    forever begin
      @(negedge clock);
      if (!reset && ((c0_d_valid && c0_d_ready) || (c1_d_valid && c1_d_ready))) begin
        if (exp_d.size() == 0) begin
          n_checks++;
          $display("FAIL d_unexpected: actual c0_d_valid %0b c1_d_valid %0b, required none",
                   c0_d_valid, c1_d_valid);
        end else if (c0_d_valid && c1_d_valid) begin
          n_checks++;
          void'(exp_d.pop_front());
          $display("FAIL d_both_valid: actual both clients valid, required one");
        end else if (c0_d_valid) begin
          chk("d_beat", dkey(1'b0, c0_d_source, c0_d_opcode, c0_d_size, c0_d_data),
              exp_d.pop_front());
        end else begin
          chk("d_beat", dkey(1'b1, c1_d_source, c1_d_opcode, c1_d_size, c1_d_data),
              exp_d.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    beat_t b;
    reset = 1'b1; m_a_ready = 1'b0;
    m_d_valid = 1'b0; m_d_opcode = 3'd0; m_d_param = 2'd0; m_d_size = 2'd0;
    m_d_source = 3'd0; m_d_denied = 1'b0; m_d_data = 32'd0;
    c0_d_ready = 1'b1; c1_d_ready = 1'b1;

    // Both clients hold Gets across reset release
    cq_push(1'b0, mk(3'd4, 2'd2, 2'b01, 30'h100, 32'd0));
    cq_push(1'b0, mk(3'd4, 2'd2, 2'b01, 30'h104, 32'd0));
    cq_push(1'b1, mk(3'd4, 2'd2, 2'b10, 30'h110, 32'd0));
    cq_push(1'b1, mk(3'd4, 2'd2, 2'b10, 30'h114, 32'd0));
    exp_push(1'b0, mk(3'd4, 2'd2, 2'b01, 30'h100, 32'd0));
    exp_push(1'b1, mk(3'd4, 2'd2, 2'b10, 30'h110, 32'd0));
    exp_push(1'b0, mk(3'd4, 2'd2, 2'b01, 30'h104, 32'd0));
    exp_push(1'b1, mk(3'd4, 2'd2, 2'b10, 30'h114, 32'd0));
    m_a_ready = 1'b1;
    repeat (3) step();
    chk("rst_m_a_valid", 96'(m_a_valid), 96'(0));
    chk("rst_c0_a_ready", 96'(c0_a_ready), 96'(0));
    chk("rst_c1_a_ready", 96'(c1_a_ready), 96'(0));
    chk("rst_d_valid", 96'({c0_d_valid, c1_d_valid}), 96'(0));
    chk("rst_m_d_ready_hi", 96'(m_d_ready), 96'(1));
    c0_d_ready = 1'b0;
    #1;
    chk("rst_m_d_ready_lo", 96'(m_d_ready), 96'(0));
    c0_d_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk("first_grant_src", 96'(m_a_source), 96'(3'b001));
    chk("first_grant_c1_rdy", 96'(c1_a_ready), 96'(0));
    step();
    chk("second_grant_src", 96'(m_a_source), 96'(3'b110));
    step();
    chk("third_grant_src", 96'(m_a_source), 96'(3'b001));
    wait_a_drain("t1_drain");
    d_send(3'b001, 3'd1, 2'd2, 32'hD000_0001);
    d_send(3'b110, 3'd1, 2'd2, 32'hD000_0002);
    d_send(3'b001, 3'd1, 2'd2, 32'hD000_0003);
    d_send(3'b110, 3'd1, 2'd2, 32'hD000_0004);

    // Client 0 two-beat PutFullData locks out a waiting client 1
    cq_push(1'b0, mk(3'd0, 2'd3, 2'b00, 30'h200, 32'hAAAA_0000));
    cq_push(1'b0, mk(3'd0, 2'd3, 2'b00, 30'h200, 32'hAAAA_0001));
    cq_push(1'b1, mk(3'd4, 2'd2, 2'b01, 30'h300, 32'd0));
    exp_push(1'b0, mk(3'd0, 2'd3, 2'b00, 30'h200, 32'hAAAA_0000));
    exp_push(1'b0, mk(3'd0, 2'd3, 2'b00, 30'h200, 32'hAAAA_0001));
    exp_push(1'b1, mk(3'd4, 2'd2, 2'b01, 30'h300, 32'd0));
    step();
    chk("burst_b0_c0_rdy", 96'(c0_a_ready), 96'(1));
    chk("burst_b0_c1_rdy", 96'(c1_a_ready), 96'(0));
    step();
    chk("burst_b1_c0_rdy", 96'(c0_a_ready), 96'(1));
    chk("burst_b1_c1_rdy", 96'(c1_a_ready), 96'(0));
    step();
    chk("burst_after_c1_rdy", 96'(c1_a_ready), 96'(1));
    wait_a_drain("t2_drain");
    d_send(3'b000, 3'd0, 2'd3, 32'd0);
    d_send(3'b101, 3'd1, 2'd2, 32'hD000_0005);

    // Stalled client-1 beat must stay on m_a while client 0 arrives
    m_a_ready = 1'b0;
    cq_push(1'b1, mk(3'd4, 2'd2, 2'b11, 30'h400, 32'd0));
    exp_push(1'b1, mk(3'd4, 2'd2, 2'b11, 30'h400, 32'd0));
    exp_push(1'b0, mk(3'd4, 2'd2, 2'b10, 30'h500, 32'd0));
    step();
    cq_push(1'b0, mk(3'd4, 2'd2, 2'b10, 30'h500, 32'd0));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_src", 96'(m_a_source), 96'(3'b111));
      chk("stall_addr", 96'(m_a_address), 96'(30'h400));
    end
    m_a_ready = 1'b1;
    #1;
    chk("stall_release_c1_rdy", 96'(c1_a_ready), 96'(1));
    wait_a_drain("t3_drain");
    d_send(3'b111, 3'd1, 2'd2, 32'hD000_0006);
    d_send(3'b010, 3'd1, 2'd2, 32'hD000_0007);

    // Client 0 saturates at four outstanding; client 1 still served
    for (int i = 0; i < 5; i++) begin
      b = mk(3'd4, 2'd2, 2'b00, 30'h600 + 30'(i * 4), 32'd0);
      cq_push(1'b0, b);
      if (i < 4) exp_push(1'b0, b);
    end
    wait_a_drain("t4_drain_a");
    step();
    chk("full_c0_rdy", 96'(c0_a_ready), 96'(0));
    chk("full_m_a_valid", 96'(m_a_valid), 96'(0));
    cq_push(1'b1, mk(3'd4, 2'd2, 2'b01, 30'h700, 32'd0));
    exp_push(1'b1, mk(3'd4, 2'd2, 2'b01, 30'h700, 32'd0));
    step();
    chk("full_skip_c1_rdy", 96'(c1_a_ready), 96'(1));
    wait_a_drain("t4_drain_b");
    exp_push(1'b0, mk(3'd4, 2'd2, 2'b00, 30'h610, 32'd0));
    d_send(3'b000, 3'd1, 2'd2, 32'hD000_0008);
    chk("unfull_c0_rdy", 96'(c0_a_ready), 96'(1));
    wait_a_drain("t4_drain_c");

    // Two-beat AccessAckData to client 1 with a toggling d_ready
    exp_d.push_back(dkey(1'b1, 2'b10, 3'd1, 2'd3, 32'hBEEF_0000));
    exp_d.push_back(dkey(1'b1, 2'b10, 3'd1, 2'd3, 32'hBEEF_0001));
    c1_d_ready = 1'b0;
    m_d_valid = 1'b1; m_d_source = 3'b110; m_d_opcode = 3'd1; m_d_size = 2'd3;
    m_d_data = 32'hBEEF_0000;
    #1;
    chk("dburst_c1_valid", 96'(c1_d_valid), 96'(1));
    chk("dburst_c0_valid", 96'(c0_d_valid), 96'(0));
    chk("dburst_c1_src", 96'(c1_d_source), 96'(2'b10));
    chk("dburst_m_rdy_lo", 96'(m_d_ready), 96'(0));
    step();
    c1_d_ready = 1'b1;
    #1;
    chk("dburst_m_rdy_hi", 96'(m_d_ready), 96'(1));
    step();
    chk("dburst_cnt_mid", 96'(dut.u_ctr1.count), 96'(1));
    m_d_data = 32'hBEEF_0001;
    c1_d_ready = 1'b0;
    step();
    chk("dburst_cnt_hold", 96'(dut.u_ctr1.count), 96'(1));
    c1_d_ready = 1'b1;
    step();
    m_d_valid = 1'b0;
    chk("dburst_cnt_done", 96'(dut.u_ctr1.count), 96'(0));

    // Retire client 0, then a stray response saturates at zero
    for (int i = 0; i < 4; i++) d_send(3'b000, 3'd1, 2'd2, 32'hC000_0000 + 32'(i));
    chk("c0_cnt_zero", 96'(dut.u_ctr0.count), 96'(0));
    d_send(3'b011, 3'd0, 2'd2, 32'd0);
    chk("c0_cnt_sat", 96'(dut.u_ctr0.count), 96'(0));

    // Reset in the middle of a client-1 burst
    cq_push(1'b1, mk(3'd1, 2'd3, 2'b11, 30'h800, 32'h0000_0001));
    cq_push(1'b1, mk(3'd1, 2'd3, 2'b11, 30'h800, 32'h0000_0002));
    exp_push(1'b1, mk(3'd1, 2'd3, 2'b11, 30'h800, 32'h0000_0001));
    step();
    step();
    m_a_ready = 1'b0;
    chk("lock_beat1_data", 96'(m_a_data), 96'(32'h0000_0002));
    reset = 1'b1;
    #1;
    chk("mid_rst_m_a_valid", 96'(m_a_valid), 96'(0));
    chk("mid_rst_a_ready", 96'({c0_a_ready, c1_a_ready}), 96'(0));
    chk("mid_rst_cnt1", 96'(dut.u_ctr1.count), 96'(0));
    c0q.delete();
    c1q.delete();
    m_a_ready = 1'b1;
    cq_push(1'b1, mk(3'd4, 2'd2, 2'b00, 30'h900, 32'd0));
    cq_push(1'b0, mk(3'd4, 2'd2, 2'b01, 30'hA00, 32'd0));
    exp_push(1'b0, mk(3'd4, 2'd2, 2'b01, 30'hA00, 32'd0));
    exp_push(1'b1, mk(3'd4, 2'd2, 2'b00, 30'h900, 32'd0));
    step();
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_grant", 96'(m_a_source), 96'(3'b001));
    wait_a_drain("t6_drain");
    chk("d_sb_empty", 96'(exp_d.size()), 96'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
